// File: rtl/double_tap_buffer.sv
// Circular delay line for converted double samples: stores the newest TAPS samples
// and streams them out newest-first, one per clock, on request.
module double_tap_buffer #(
    parameter int TAPS = 4,
    parameter int DW   = 64,
    parameter int AW   = 2
) (
    input  logic          clk_operation,
    input  logic          rst,
    input  logic [DW-1:0] double_in,
    input  logic          in_valid,
    input  logic          tap_req,
    input  logic          clr_ovf,
    output logic [DW-1:0] tap_out,
    output logic [AW-1:0] tap_idx,
    output logic          tap_valid,
    output logic          tap_last,
    output logic          busy,
    output logic [AW:0]   fill_count,
    output logic          full,
    output logic          overflow
);

    localparam logic [AW:0]   L_TAPS   = (AW+1)'(TAPS);
    localparam logic [AW-1:0] L_LAST_K = AW'(TAPS - 1);

    typedef enum logic {S_IDLE, S_READ} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [DW-1:0] r_mem [TAPS];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_base;
    logic [AW-1:0] r_k;
    logic [AW:0]   r_fill;
    logic          r_pend_vld;
    logic [DW-1:0] r_pend_data;
    logic [DW-1:0] r_tap_out;
    logic [AW-1:0] r_tap_idx;
    logic          r_tap_valid;
    logic          r_tap_last;
    logic          r_ovf;

    logic          w_idle;
    logic          w_busy;
    logic          w_wr_en;
    logic [DW-1:0] w_wr_data;
    logic          w_start;
    logic          w_drop;
    logic          w_last_k;
    logic [AW-1:0] w_rd_addr;

    assign w_idle    = (r_state == S_IDLE);
    assign w_busy    = !w_idle || r_tap_valid;
    // A held sample always commits ahead of a newly arriving one.
    assign w_wr_en   = w_idle && (r_pend_vld || in_valid);
    assign w_wr_data = r_pend_vld ? r_pend_data : double_in;
    assign w_start   = tap_req && !w_busy;
    assign w_drop    = !w_idle && in_valid && r_pend_vld;
    assign w_last_k  = (r_k == L_LAST_K);
    assign w_rd_addr = r_base - AW'(1) - r_k;

    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start)  w_state_nxt = S_READ;
            S_READ:  if (w_last_k) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_mem[i] <= '0;
            end
            r_wp        <= '0;
            r_base      <= '0;
            r_k         <= '0;
            r_fill      <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_data <= '0;
            r_tap_out   <= '0;
            r_tap_idx   <= '0;
            r_tap_valid <= 1'b0;
            r_tap_last  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wp] <= w_wr_data;
                r_wp        <= r_wp + AW'(1);
                if (r_fill != L_TAPS) begin
                    r_fill <= r_fill + (AW+1)'(1);
                end
            end

            if (w_idle) begin
                r_pend_vld <= r_pend_vld && in_valid;
                if (r_pend_vld && in_valid) begin
                    r_pend_data <= double_in;
                end
            end else if (in_valid && !r_pend_vld) begin
                r_pend_vld  <= 1'b1;
                r_pend_data <= double_in;
            end

            // Base includes a same-edge write so a concurrent sample becomes tap 0.
            if (w_start) begin
                r_base <= r_wp + AW'(w_wr_en);
                r_k    <= '0;
            end

            if (!w_idle) begin
                r_tap_out   <= r_mem[w_rd_addr];
                r_tap_idx   <= r_k;
                r_tap_valid <= 1'b1;
                r_tap_last  <= w_last_k;
                r_k         <= r_k + AW'(1);
            end else begin
                r_tap_valid <= 1'b0;
                r_tap_last  <= 1'b0;
            end

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign tap_out    = r_tap_out;
    assign tap_idx    = r_tap_idx;
    assign tap_valid  = r_tap_valid;
    assign tap_last   = r_tap_last;
    assign busy       = w_busy;
    assign fill_count = r_fill;
    assign full       = (r_fill == L_TAPS);
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_double_tap_buffer.sv
// Directed plus randomized bench for double_tap_buffer, checked against a
// sample-history queue model with immediate assertions.
module tb_double_tap_buffer;

    localparam int TAPS = 4;
    localparam int DW   = 64;
    localparam int AW   = 2;

    localparam logic [63:0] D1 = 64'h3FF0000000000000;
    localparam logic [63:0] D2 = 64'h4000000000000000;
    localparam logic [63:0] D7 = 64'h401C000000000000;
    localparam logic [63:0] D8 = 64'h4020000000000000;
    localparam logic [63:0] D9 = 64'h4022000000000000;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] double_in;
    logic          in_valid;
    logic          tap_req;
    logic          clr_ovf;
    logic [DW-1:0] tap_out;
    logic [AW-1:0] tap_idx;
    logic          tap_valid;
    logic          tap_last;
    logic          busy;
    logic [AW:0]   fill_count;
    logic          full;
    logic          overflow;

    double_tap_buffer #(.TAPS(TAPS), .DW(DW), .AW(AW)) dut (
        .clk_operation(clk),
        .rst          (rst),
        .double_in    (double_in),
        .in_valid     (in_valid),
        .tap_req      (tap_req),
        .clr_ovf      (clr_ovf),
        .tap_out      (tap_out),
        .tap_idx      (tap_idx),
        .tap_valid    (tap_valid),
        .tap_last     (tap_last),
        .busy         (busy),
        .fill_count   (fill_count),
        .full         (full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Model: history newest-first, at most one held sample, and the planned burst.
    logic [63:0] hist[$];
    logic [63:0] pend[$];
    logic [63:0] plan[$];
    logic [63:0] obs_taps[$];
    logic        m_tv;
    logic [63:0] m_out;
    int          m_idx;
    logic        m_last;
    logic        m_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        hist.delete();
        pend.delete();
        plan.delete();
        m_tv   = 1'b0;
        m_out  = '0;
        m_idx  = 0;
        m_last = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge(input logic iv, input logic [63:0] d, input logic req, input logic clr);
        logic reading;
        logic busy_b;
        logic ovf_set;
        reading = (plan.size() > 0);
        busy_b  = reading || m_tv;
        ovf_set = 1'b0;
        if (!reading) begin
            if (pend.size() > 0) begin
                hist.push_front(pend.pop_front());
                if (iv) pend.push_back(d);
            end else if (iv) begin
                hist.push_front(d);
            end
            while (hist.size() > TAPS) void'(hist.pop_back());
        end else if (iv) begin
            if (pend.size() == 0) pend.push_back(d);
            else ovf_set = 1'b1;
        end
        if (reading) begin
            m_out  = plan.pop_front();
            m_idx  = TAPS - 1 - plan.size();
            m_tv   = 1'b1;
            m_last = (m_idx == TAPS - 1);
        end else begin
            m_tv   = 1'b0;
            m_last = 1'b0;
        end
        if (req && !busy_b) begin
            for (int k = 0; k < TAPS; k++) begin
                plan.push_back((k < hist.size()) ? hist[k] : 64'h0);
            end
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic check_outputs();
        chk("tap_valid", 64'(tap_valid), 64'(m_tv));
        chk("tap_last", 64'(tap_last), 64'(m_last));
        chk("busy", 64'(busy), 64'((plan.size() > 0) || m_tv));
        chk("fill_count", 64'(fill_count), 64'(hist.size()));
        chk("full", 64'(full), 64'(hist.size() == TAPS));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (m_tv) begin
            chk("tap_out", tap_out, m_out);
            chk("tap_idx", 64'(tap_idx), 64'(m_idx));
        end
        if (tap_valid === 1'b1) obs_taps.push_back(tap_out);
    endtask

    task automatic cyc(input logic iv, input logic [63:0] d, input logic req, input logic clr);
        in_valid  = iv;
        double_in = d;
        tap_req   = req;
        clr_ovf   = clr;
        @(posedge clk);
        model_edge(iv, d, req, clr);
        #1;
        in_valid = 1'b0;
        tap_req  = 1'b0;
        clr_ovf  = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    function automatic logic [63:0] obs_at(input int k);
        return (k < obs_taps.size()) ? obs_taps[k] : 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    initial begin
        logic [63:0] exp4[4];
        logic        seen9;

        rst = 1'b0; in_valid = 1'b0; tap_req = 1'b0; clr_ovf = 1'b0; double_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_tap_valid", 64'(tap_valid), 64'h0);
        chk("rst_tap_out", tap_out, 64'h0);
        chk("rst_tap_idx", 64'(tap_idx), 64'h0);
        chk("rst_tap_last", 64'(tap_last), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_fill", 64'(fill_count), 64'h0);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_ovf", 64'(overflow), 64'h0);
        idle(2);

        // Partial fill
        cyc(1'b1, D1, 1'b0, 1'b0);
        cyc(1'b1, D2, 1'b0, 1'b0);
        obs_taps.delete();
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        idle(6);
        exp4 = '{D2, D1, 64'h0, 64'h0};
        chk("pf_len", 64'(obs_taps.size()), 64'd4);
        for (int k = 0; k < 4; k++) chk("pf_tap", obs_at(k), exp4[k]);

        // Wrap-around
        for (int i = 1; i <= 6; i++) cyc(1'b1, $realtobits(real'(i)), 1'b0, 1'b0);
        chk("wrap_fill", 64'(fill_count), 64'd4);
        chk("wrap_full", 64'(full), 64'd1);
        obs_taps.delete();
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        idle(6);
        for (int k = 0; k < 4; k++) chk("wrap_tap", obs_at(k), $realtobits(real'(6 - k)));

        // Simultaneous write and request
        obs_taps.delete();
        cyc(1'b1, D7, 1'b1, 1'b0);
        idle(6);
        chk("simul_tap0", obs_at(0), D7);

        // Writes during a burst, second one dropped
        obs_taps.delete();
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        idle(1);
        cyc(1'b1, D8, 1'b0, 1'b0);
        cyc(1'b1, D9, 1'b0, 1'b0);
        idle(4);
        exp4 = '{D7, $realtobits(6.0), $realtobits(5.0), $realtobits(4.0)};
        for (int k = 0; k < 4; k++) chk("wdb_tap", obs_at(k), exp4[k]);
        chk("wdb_ovf", 64'(overflow), 64'd1);
        cyc(1'b0, 64'h0, 1'b0, 1'b1);
        chk("clr_ovf", 64'(overflow), 64'd0);
        obs_taps.delete();
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        idle(6);
        chk("wdb_next_tap0", obs_at(0), D8);
        seen9 = 1'b0;
        foreach (obs_taps[i]) if (obs_taps[i] == D9) seen9 = 1'b1;
        chk("wdb_no_drop_sample", 64'(seen9), 64'd0);

        // Reset mid-burst
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        idle(2);
        rst = 1'b0;
        #1;
        model_reset();
        chk("mrst_tap_valid", 64'(tap_valid), 64'h0);
        chk("mrst_busy", 64'(busy), 64'h0);
        chk("mrst_tap_out", tap_out, 64'h0);
        chk("mrst_fill", 64'(fill_count), 64'h0);
        chk("mrst_tap_last", 64'(tap_last), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        obs_taps.delete();
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        idle(6);
        chk("mrst_len", 64'(obs_taps.size()), 64'd4);
        for (int k = 0; k < 4; k++) chk("mrst_tap", obs_at(k), 64'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), {$urandom, $urandom},
                $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
